// File: rtl/pwm_leds_wb.sv
// Wishbone-controlled PWM LED driver: CTRL/PRESCALE/DUTY registers, prescaled timebase, glitch-free duty update.
// Single-cycle ack one clock after accept; at most one access every two clocks; LEDs registered (1 clk).
module pwm_leds_wb #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LEDS   = 4,
    parameter int PWM_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_LEDS-1:0]   led,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_write,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack
);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] A_PRE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(7);

    logic [1:0]          r_ctrl;
    logic [15:0]         r_prescale;
    logic [15:0]         r_pre_cnt;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [PWM_BITS-1:0] r_duty    [NUM_LEDS];
    logic [PWM_BITS-1:0] r_duty_sh [NUM_LEDS];
    logic [NUM_LEDS-1:0] r_led;
    logic                r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_wr_ctrl;
    logic                  w_wr_pre;
    logic [NUM_LEDS-1:0]   w_wr_duty;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_tick;
    logic                  w_wrap;

    // The ack blocks the next accept, so a held request is serviced every other clock.
    always_comb begin
        w_accept  = wbs_cycle & wbs_strobe & ~r_ack;
        w_wr      = w_accept & wbs_write;
        w_rd      = w_accept & ~wbs_write;
        w_wr_ctrl = w_wr && (wbs_address == A_CTRL);
        w_wr_pre  = w_wr && (wbs_address == A_PRE);
        w_rdata   = '0;
        if (wbs_address == A_CTRL)
            w_rdata[1:0] = r_ctrl;
        else if (wbs_address == A_PRE)
            w_rdata[15:0] = r_prescale;
        else if (wbs_address == A_STATUS)
            w_rdata[PWM_BITS-1:0] = r_pwm_cnt;
        for (int i = 0; i < NUM_LEDS; i++) begin
            w_wr_duty[i] = w_wr && (wbs_address == ADDR_WIDTH'(2 + i));
            if (wbs_address == ADDR_WIDTH'(2 + i))
                w_rdata[PWM_BITS-1:0] = r_duty[i];
        end
    end

    assign w_tick = r_ctrl[0] && (r_pre_cnt == r_prescale);
    assign w_wrap = w_tick && (r_pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pre_cnt  <= '0;
            r_pwm_cnt  <= '0;
            r_led      <= '0;
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_duty[i]    <= '0;
                r_duty_sh[i] <= '0;
            end
        end else begin
            r_ack <= w_accept;
            if (w_rd)
                r_rdata <= w_rdata;
            if (w_wr_ctrl)
                r_ctrl <= wbs_writedata[1:0];
            if (w_wr_pre)
                r_prescale <= wbs_writedata[15:0];

            if (!r_ctrl[0]) begin
                r_pre_cnt <= '0;
                r_pwm_cnt <= '0;
            end else begin
                if (w_wr_pre || w_tick)
                    r_pre_cnt <= '0;
                else
                    r_pre_cnt <= r_pre_cnt + 16'd1;
                if (w_tick)
                    r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            end

            // Shadow samples the pre-write DUTY value, so a write on the wrap cycle waits a full period.
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (w_wr_duty[i])
                    r_duty[i] <= wbs_writedata[PWM_BITS-1:0];
                if (!r_ctrl[0] || w_wrap)
                    r_duty_sh[i] <= r_duty[i];
                r_led[i] <= r_ctrl[0] ? ((r_pwm_cnt < r_duty_sh[i]) ^ r_ctrl[1]) : r_ctrl[1];
            end
        end
    end

    assign led          = r_led;
    assign wbs_ack      = r_ack;
    assign wbs_readdata = r_rdata;
endmodule
